// File: rtl/sym_cn_lut_loader.sv
// sym_cn_lut_loader: write-side loader for the symmetric CN IB-LUT RAM.
// Pairs a serial valid/ready stream of LUT entries into bank0/bank1 words
// and issues one page write per pair, pages 0..PAGE_NUM-1 under one offset.
//
// Ports:
//   write_clk, rst            clock, synchronous active-high reset
//   load_start, load_offset   start pulse and target write_addr_offset
//   lut_entry_in/valid/ready  entry stream (even idx -> bank0, odd -> bank1)
//   lut_in_bank0/1            registered bank write data
//   page_write_addr           registered page address
//   write_addr_offset         registered ping-pong offset
//   we                        1-cycle write pulse per page
//   busy, load_done           load in progress / 1-cycle completion pulse
//
// Optional feature macro LUT_LOAD_ABORT_EN adds input load_abort, which
// drops an in-progress load (GET0/GET1) back to IDLE without load_done.
module sym_cn_lut_loader #(
    parameter int DATA_W      = 3,
    parameter int PAGE_ADDR_W = 5,
    parameter int PAGE_NUM    = 32
) (
    input  logic                   write_clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_offset,
    input  logic [DATA_W-1:0]      lut_entry_in,
    input  logic                   lut_entry_valid,
`ifdef LUT_LOAD_ABORT_EN
    input  logic                   load_abort,
`endif
    output logic                   lut_entry_ready,
    output logic [DATA_W-1:0]      lut_in_bank0,
    output logic [DATA_W-1:0]      lut_in_bank1,
    output logic [PAGE_ADDR_W-1:0] page_write_addr,
    output logic                   write_addr_offset,
    output logic                   we,
    output logic                   busy,
    output logic                   load_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET0   = 2'd1,
        GET1   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [PAGE_ADDR_W-1:0] LAST_PAGE =
        PAGE_ADDR_W'(PAGE_NUM - 1);

    state_t                   state;
    state_t                   state_next;
    logic [PAGE_ADDR_W-1:0]   page_cnt;
    logic [DATA_W-1:0]        bank0_stage;
    logic                     ready;
    logic                     take0;
    logic                     take1;
    logic                     start_acc;
    logic                     finish;
    logic                     last_page;
`ifdef LUT_LOAD_ABORT_EN
    logic                     abort_acc;
`endif

    assign last_page       = (page_cnt == LAST_PAGE);
    assign lut_entry_ready = ready;

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        take0      = 1'b0;
        take1      = 1'b0;
        start_acc  = 1'b0;
        finish     = 1'b0;
`ifdef LUT_LOAD_ABORT_EN
        abort_acc  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (load_start) begin
                    start_acc  = 1'b1;
                    state_next = GET0;
                end
            end
            GET0, GET1: begin
                ready = 1'b1;
`ifdef LUT_LOAD_ABORT_EN
                // Abort wins over a same-cycle entry so nothing is consumed.
                if (load_abort) begin
                    ready      = 1'b0;
                    abort_acc  = 1'b1;
                    state_next = IDLE;
                end
`endif
                if (ready && lut_entry_valid) begin
                    if (state == GET0) begin
                        take0      = 1'b1;
                        state_next = GET1;
                    end else begin
                        take1      = 1'b1;
                        state_next = last_page ? FINISH : GET0;
                    end
                end
            end
            FINISH: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state             <= IDLE;
            page_cnt          <= '0;
            bank0_stage       <= '0;
            lut_in_bank0      <= '0;
            lut_in_bank1      <= '0;
            page_write_addr   <= '0;
            write_addr_offset <= 1'b0;
            we                <= 1'b0;
            busy              <= 1'b0;
            load_done         <= 1'b0;
        end else begin
            state     <= state_next;
            we        <= take1;
            load_done <= finish;
            if (start_acc) begin
                write_addr_offset <= load_offset;
                page_cnt          <= '0;
                busy              <= 1'b1;
            end
            if (take0) begin
                bank0_stage <= lut_entry_in;
            end
            if (take1) begin
                lut_in_bank0    <= bank0_stage;
                lut_in_bank1    <= lut_entry_in;
                page_write_addr <= page_cnt;
                // Hold at the last page; FINISH ends the load instead.
                if (!last_page) begin
                    page_cnt <= page_cnt + 1'b1;
                end
            end
            if (finish) begin
                busy <= 1'b0;
            end
`ifdef LUT_LOAD_ABORT_EN
            if (abort_acc) begin
                busy <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sym_cn_lut_loader.sv
// tb_sym_cn_lut_loader: self-checking bench for sym_cn_lut_loader.
// Table of load scenarios plus hand-written reset/abort sequences.
module tb_sym_cn_lut_loader;

    localparam int DW = 3;
    localparam int PW = 5;
    localparam int PN = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          load_offset = 1'b0;
    logic [DW-1:0] lut_entry_in = '0;
    logic          lut_entry_valid = 1'b0;
`ifdef LUT_LOAD_ABORT_EN
    logic          load_abort = 1'b0;
`endif
    logic          lut_entry_ready;
    logic [DW-1:0] lut_in_bank0;
    logic [DW-1:0] lut_in_bank1;
    logic [PW-1:0] page_write_addr;
    logic          write_addr_offset;
    logic          we;
    logic          busy;
    logic          load_done;

    always #5 clk = ~clk;

    sym_cn_lut_loader #(.DATA_W(DW), .PAGE_ADDR_W(PW), .PAGE_NUM(PN)) dut (
        .write_clk         (clk),
        .rst               (rst),
        .load_start        (load_start),
        .load_offset       (load_offset),
        .lut_entry_in      (lut_entry_in),
        .lut_entry_valid   (lut_entry_valid),
`ifdef LUT_LOAD_ABORT_EN
        .load_abort        (load_abort),
`endif
        .lut_entry_ready   (lut_entry_ready),
        .lut_in_bank0      (lut_in_bank0),
        .lut_in_bank1      (lut_in_bank1),
        .page_write_addr   (page_write_addr),
        .write_addr_offset (write_addr_offset),
        .we                (we),
        .busy              (busy),
        .load_done         (load_done)
    );

    // {offset, page, bank0, bank1}
    typedef logic [1+PW+2*DW-1:0] wr_t;

    typedef struct {
        bit off;
        bit stall;
        int busy_pg;
        int exp_writes;
        int exp_done;
    } vec_t;

    wr_t sbq[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  writes = 0;
    int  dones = 0;
    bit  prev_we = 0;

    task automatic chk(bit ok, string name, longint got, longint want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        wr_t got;
        wr_t exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we = 0;
                continue;
            end
            got = {write_addr_offset, page_write_addr,
                   lut_in_bank0, lut_in_bank1};
            if (we) begin
                chk(!prev_we, "we_back_to_back", 1, 0);
                if (sbq.size() == 0) begin
                    chk(0, "unexpected_we", got, 0);
                end else begin
                    exp = sbq.pop_front();
                    chk(got == exp, "write", got, exp);
                end
                writes++;
            end
            if (load_done) begin
                chk(prev_we, "done_after_we", prev_we, 1);
                chk(busy == 1'b0, "busy_at_done", busy, 0);
                dones++;
            end
            prev_we = we;
        end
    endtask

    task automatic chk_reset_state(string tag);
        chk(we == 0, {tag, "_we"}, we, 0);
        chk(busy == 0, {tag, "_busy"}, busy, 0);
        chk(load_done == 0, {tag, "_done"}, load_done, 0);
        chk(lut_entry_ready == 0, {tag, "_ready"}, lut_entry_ready, 0);
        chk(lut_in_bank0 == 0, {tag, "_bank0"}, lut_in_bank0, 0);
        chk(lut_in_bank1 == 0, {tag, "_bank1"}, lut_in_bank1, 0);
        chk(page_write_addr == 0, {tag, "_addr"}, page_write_addr, 0);
        chk(write_addr_offset == 0, {tag, "_off"}, write_addr_offset, 0);
    endtask

    task automatic start_load(bit off);
        load_start  = 1'b1;
        load_offset = off;
        tick();
        load_start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", busy, 1);
    endtask

    // Feed entries 0..stop_idx-1; push expected page on each odd accept.
    task automatic feed(bit off, bit stall, int busy_pg, int stop_idx);
        int  idx = 0;
        int  cyc = 0;
        bit  hs;
        bit  fired = 0;
        while (idx < stop_idx) begin
            lut_entry_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            lut_entry_in    = DW'(idx % 8);
            load_start      = 1'b0;
            if (busy_pg >= 0 && idx == 2 * busy_pg && !fired) begin
                load_start  = 1'b1;
                load_offset = ~off;
                fired       = 1;
            end
            @(negedge clk);
            hs = lut_entry_valid && lut_entry_ready;
            tick();
            if (hs) begin
                if (idx % 2 == 1)
                    sbq.push_back({off, PW'(idx / 2),
                                   DW'((idx - 1) % 8), DW'(idx % 8)});
                idx++;
            end
            cyc++;
            if (cyc > 3000) begin
                chk(0, "feed_timeout", idx, stop_idx);
                break;
            end
        end
        lut_entry_valid = 1'b0;
        load_start      = 1'b0;
    endtask

    task automatic run_load(vec_t v);
        int w0 = writes;
        int d0 = dones;
        int w  = 0;
        start_load(v.off);
        feed(v.off, v.stall, v.busy_pg, 2 * PN);
        while (dones == d0 && w < 10) begin
            tick();
            w++;
        end
        chk(dones - d0 == v.exp_done, "load_done_count", dones - d0, v.exp_done);
        chk(writes - w0 == v.exp_writes, "write_count", writes - w0, v.exp_writes);
        chk(sbq.size() == 0, "sb_empty", sbq.size(), 0);
        repeat (4) tick();
        chk(busy == 1'b0, "idle_after_load", busy, 0);
        chk(dones - d0 == v.exp_done, "single_done", dones - d0, v.exp_done);
        chk(write_addr_offset == v.off, "offset_held", write_addr_offset, v.off);
    endtask

    initial begin
        vec_t tbl[4];
        int   w0;
        int   d0;
        tbl[0] = '{off: 1'b1, stall: 1'b0, busy_pg: -1, exp_writes: PN, exp_done: 1};
        tbl[1] = '{off: 1'b0, stall: 1'b1, busy_pg: -1, exp_writes: PN, exp_done: 1};
        tbl[2] = '{off: 1'b1, stall: 1'b0, busy_pg: 10, exp_writes: PN, exp_done: 1};
        tbl[3] = '{off: 1'b0, stall: 1'b1, busy_pg: 3,  exp_writes: PN, exp_done: 1};

        fork
            monitor();
        join_none

        rst = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        lut_entry_valid = 1'b1;
        @(negedge clk);
        chk(lut_entry_ready == 1'b0, "idle_ready", lut_entry_ready, 0);
        tick();
        lut_entry_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_load(tbl[i]);
        end

        w0 = writes;
        start_load(1'b0);
        feed(1'b0, 1'b0, -1, 34);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk(writes - w0 == 17, "pages_before_rst", writes - w0, 17);
        chk(sbq.size() == 0, "sb_empty_rst", sbq.size(), 0);
        chk_reset_state("midreset");
        rst = 1'b0;
        w0 = writes;
        lut_entry_valid = 1'b1;
        repeat (10) tick();
        lut_entry_valid = 1'b0;
        chk(writes == w0, "no_we_after_rst", writes - w0, 0);
        run_load(tbl[0]);

`ifdef LUT_LOAD_ABORT_EN
        w0 = writes;
        d0 = dones;
        start_load(1'b1);
        feed(1'b1, 1'b0, -1, 11);
        load_abort      = 1'b1;
        lut_entry_valid = 1'b1;
        lut_entry_in    = 3'd3;
        @(negedge clk);
        chk(lut_entry_ready == 1'b0, "abort_ready", lut_entry_ready, 0);
        tick();
        load_abort      = 1'b0;
        lut_entry_valid = 1'b0;
        chk(busy == 1'b0, "abort_busy", busy, 0);
        repeat (6) tick();
        chk(writes - w0 == 5, "abort_pages", writes - w0, 5);
        chk(dones == d0, "abort_no_done", dones - d0, 0);
        chk(sbq.size() == 0, "abort_sb_empty", sbq.size(), 0);
`else
        d0 = dones;
        repeat (4) tick();
        chk(dones == d0, "quiet_idle", dones - d0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
